// File: rtl/lnvd_frame_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : lnvd_frame_unpacker
//  Purpose  : Receives four-channel frames from the LNVD downsampler. Each
//             level change of smp_clk captures {data_in4..data_in1} into a
//             small frame FIFO. Frames are then emitted one 12-bit channel
//             per beat over a valid/ready stream.
//  Ports    : clk, rst        - system clock, synchronous active-high reset
//             smp_clk         - frame toggle (same clock domain as clk)
//             data_in1..4     - channel samples, stable across a toggle
//             ch_data/ch_id   - current beat payload and channel index
//             ch_valid/ready  - stream handshake
//             frame_first     - marks the channel-0 beat of each frame
//             fifo_level      - frames waiting in the FIFO (holding excluded)
//             overflow        - sticky dropped-frame flag
//             drop_cnt        - saturating dropped-frame counter
//  Revision : 1.0 - initial release
// ============================================================================
module lnvd_frame_unpacker #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          smp_clk,
  input  logic [11:0]                   data_in1,
  input  logic [11:0]                   data_in2,
  input  logic [11:0]                   data_in3,
  input  logic [11:0]                   data_in4,
  output logic [11:0]                   ch_data,
  output logic [1:0]                    ch_id,
  output logic                          ch_valid,
  input  logic                          ch_ready,
  output logic                          frame_first,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);

  localparam int c_addr_w  = $clog2(FIFO_DEPTH);
  localparam int c_level_w = c_addr_w + 1;
  localparam logic [c_level_w-1:0] c_depth = c_level_w'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_smp_d;
  logic [47:0]             r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]     r_wr_ptr, r_rd_ptr;
  logic [c_level_w-1:0]    r_level;
  logic [47:0]             r_hold;
  logic [1:0]              r_ch_id, w_ch_id_nxt;
  logic                    r_ch_valid, w_ch_valid_nxt;
  logic                    r_overflow;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;

  logic                    w_tog, w_full, w_push, w_drop, w_pop, w_xfer;
  logic [11:0]             w_ch_data;

  assign w_tog  = (smp_clk != r_smp_d);
  // Full is judged on the pre-pop level so a same-cycle drain never makes
  // room for a frame arriving in that cycle.
  assign w_full = (r_level == c_depth);
  assign w_push = w_tog && !w_full;
  assign w_drop = w_tog && w_full;
  assign w_xfer = r_ch_valid && ch_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ch_id_nxt    = r_ch_id;
    w_ch_valid_nxt = r_ch_valid;
    w_pop          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop          = 1'b1;
          w_ch_id_nxt    = 2'd0;
          w_ch_valid_nxt = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (r_ch_id != 2'd3) begin
            w_ch_id_nxt = r_ch_id + 2'd1;
          end else if (r_level != '0) begin
            // Reload straight from the FIFO: no bubble between frames.
            w_pop       = 1'b1;
            w_ch_id_nxt = 2'd0;
          end else begin
            w_ch_valid_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ch_data = 12'd0;
    if (r_state == S_SEND) begin
      unique case (r_ch_id)
        2'd0: w_ch_data = r_hold[11:0];
        2'd1: w_ch_data = r_hold[23:12];
        2'd2: w_ch_data = r_hold[35:24];
        2'd3: w_ch_data = r_hold[47:36];
        default: w_ch_data = 12'd0;
      endcase
    end
  end

  // Frame storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {data_in4, data_in3, data_in2, data_in1};
    end
  end

  always_ff @(posedge clk) begin
    // Track the toggle level even in reset so release never sees a toggle.
    r_smp_d <= smp_clk;
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_hold     <= '0;
      r_state    <= S_IDLE;
      r_ch_id    <= 2'd0;
      r_ch_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ch_id    <= w_ch_id_nxt;
      r_ch_valid <= w_ch_valid_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_level_w'(1);
        2'b01:   r_level <= r_level - c_level_w'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (!(&r_drop_cnt)) begin
          r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
      end
    end
  end

  assign ch_data     = w_ch_data;
  assign ch_id       = r_ch_id;
  assign ch_valid    = r_ch_valid;
  assign frame_first = r_ch_valid && (r_ch_id == 2'd0);
  assign fifo_level  = r_level;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lnvd_frame_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lnvd_frame_unpacker
//  Purpose  : Self-checking bench for lnvd_frame_unpacker. A reference model
//             treats the block as a store of at most FIFO_DEPTH+1 frames and
//             predicts the beat sequence and dropped frames from that.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lnvd_frame_unpacker;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        smp_clk;
  logic [11:0] data_in1, data_in2, data_in3, data_in4;
  logic        ch_ready;

  logic [11:0] ch_data;
  logic [1:0]  ch_id;
  logic        ch_valid, frame_first, overflow;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  logic [11:0] w2_ch_data;
  logic [1:0]  w2_ch_id;
  logic        w2_ch_valid, w2_frame_first, w2_overflow;
  logic [2:0]  w2_fifo_level;
  logic [1:0]  w2_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  lnvd_frame_unpacker #(.FIFO_DEPTH(FIFO_DEPTH), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .smp_clk(smp_clk),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
    .ch_data(ch_data), .ch_id(ch_id), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .frame_first(frame_first), .fifo_level(fifo_level),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  lnvd_frame_unpacker #(.FIFO_DEPTH(FIFO_DEPTH), .DROP_CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .smp_clk(smp_clk),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
    .ch_data(w2_ch_data), .ch_id(w2_ch_id), .ch_valid(w2_ch_valid), .ch_ready(ch_ready),
    .frame_first(w2_frame_first), .fifo_level(w2_fifo_level),
    .overflow(w2_overflow), .drop_cnt(w2_drop_cnt)
  );

  // ---------------- reference model ----------------
  // Expected beats as {id, data}. A frame occupies the block from capture
  // until its channel-3 beat is accepted; a capture seen while FIFO_DEPTH+1
  // frames are held is dropped.
  logic [13:0] exp_beats[$];
  int          m_held  = 0;
  int          m_drops = 0;
  logic        m_prev;

  always @(negedge clk) begin
    logic [13:0] e;
    logic        done;
    if (rst) begin
      exp_beats.delete();
      m_held  = 0;
      m_drops = 0;
      m_prev  = smp_clk;
    end else begin
      done = 1'b0;
      if (ch_valid === 1'b1 && ch_ready === 1'b1) begin
        n_checks++;
        if (exp_beats.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got id=%0d data=%h, required no beat", ch_id, ch_data);
        end else begin
          e = exp_beats.pop_front();
          if ({ch_id, ch_data, frame_first} !== {e, (e[13:12] == 2'd0)}) begin
            n_fail++;
            $display("FAIL beat: got id=%0d data=%h first=%0d, required id=%0d data=%h first=%0d",
                     ch_id, ch_data, frame_first, e[13:12], e[11:0], (e[13:12] == 2'd0));
          end
          if (e[13:12] == 2'd3) done = 1'b1;
        end
      end
      if (smp_clk !== m_prev) begin
        if (m_held == FIFO_DEPTH + 1) begin
          m_drops++;
        end else begin
          exp_beats.push_back({2'd0, data_in1});
          exp_beats.push_back({2'd1, data_in2});
          exp_beats.push_back({2'd2, data_in3});
          exp_beats.push_back({2'd3, data_in4});
          m_held++;
        end
        m_prev = smp_clk;
      end
      if (done) m_held--;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_frame(input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d);
    data_in1 = a; data_in2 = b; data_in3 = c; data_in4 = d;
    smp_clk  = ~smp_clk;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({ch_valid, ch_id, ch_data, frame_first, fifo_level, overflow, drop_cnt} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0d id=%0d data=%h first=%0d level=%0d ovf=%0d drop=%0d, required all 0",
               ch_valid, ch_id, ch_data, frame_first, fifo_level, overflow, drop_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    ch_ready = 1'b1;
    toggle_frame(12'h111, 12'h222, 12'h333, 12'hABC);
    tick();
    n_checks++;
    if (ch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency_early: got valid=%0d, required 0", ch_valid);
    end
    tick();
    n_checks++;
    if ({ch_valid, ch_id, ch_data, frame_first} !== {1'b1, 2'd0, 12'h111, 1'b1}) begin
      n_fail++;
      $display("FAIL single_first_beat: got valid=%0d id=%0d data=%h first=%0d, required 1/0/111/1",
               ch_valid, ch_id, ch_data, frame_first);
    end
    tick(); tick(); tick();
    n_checks++;
    if ({ch_id, ch_data} !== {2'd3, 12'hABC}) begin
      n_fail++;
      $display("FAIL single_last_beat: got id=%0d data=%h, required 3/abc", ch_id, ch_data);
    end
    tick();
    n_checks++;
    if ({ch_valid, fifo_level} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL single_end: got valid=%0d level=%0d, required 0/0", ch_valid, fifo_level);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_ready = 1'b0;
    toggle_frame(12'h111, 12'h222, 12'h333, 12'hABC);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({ch_valid, ch_id, ch_data} !== {1'b1, 2'd0, 12'h111}) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got valid=%0d id=%0d data=%h, required 1/0/111",
                 i, ch_valid, ch_id, ch_data);
      end
      tick();
    end
    ch_ready = 1'b1;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (ch_valid !== 1'b0 || exp_beats.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got valid=%0d pending=%0d, required 0/0", ch_valid, exp_beats.size());
    end
  endtask

  task automatic fill_six();
    ch_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      toggle_frame(12'(n), 12'(n), 12'(n), 12'(n));
      tick(); tick(); tick();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_six();
    tick(); tick();
    n_checks++;
    if ({fifo_level, overflow, drop_cnt, ch_valid, ch_data} !== {3'd4, 1'b1, 8'd1, 1'b1, 12'd0}) begin
      n_fail++;
      $display("FAIL overflow_state: got level=%0d ovf=%0d drop=%0d valid=%0d data=%h, required 4/1/1/1/000",
               fifo_level, overflow, drop_cnt, ch_valid, ch_data);
    end
    ch_ready = 1'b1;
    repeat (30) tick();
    n_checks++;
    if (ch_valid !== 1'b0 || exp_beats.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_drain: got valid=%0d pending=%0d, required 0/0", ch_valid, exp_beats.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ch_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      toggle_frame($urandom_range(4095), $urandom_range(4095), $urandom_range(4095), $urandom_range(4095));
      tick(); tick(); tick();
    end
    tick();
    ch_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if ({ch_valid, ch_id} !== {1'b1, 2'(i % 4)}) begin
        n_fail++;
        $display("FAIL b2b beat %0d: got valid=%0d id=%0d, required 1/%0d", i, ch_valid, ch_id, i % 4);
      end
      tick();
    end
    n_checks++;
    if (ch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got valid=%0d, required 0", ch_valid);
    end
  endtask

  task automatic test_reset_behaviour();
    // Level change hidden inside reset must not be taken as a frame.
    rst = 1'b1;
    smp_clk = ~smp_clk;
    tick(); tick();
    rst = 1'b0;
    ch_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({ch_valid, fifo_level} !== {1'b0, 3'd0}) begin
        n_fail++;
        $display("FAIL rst_no_push cycle %0d: got valid=%0d level=%0d, required 0/0", i, ch_valid, fifo_level);
      end
    end
    // Reset in the middle of a frame with frames queued and overflow set.
    fill_six();
    ch_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({ch_valid, fifo_level, overflow, drop_cnt} !== {1'b0, 3'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_send: got valid=%0d level=%0d ovf=%0d drop=%0d, required 0/0/0/0",
               ch_valid, fifo_level, overflow, drop_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (ch_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_discard cycle %0d: got valid=%0d, required 0", i, ch_valid);
      end
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    ch_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      toggle_frame(12'(n), 12'(n), 12'(n), 12'(n));
      tick(); tick(); tick();
    end
    n_checks++;
    if ({w2_drop_cnt, w2_overflow} !== {2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL drop_saturate: got drop=%0d ovf=%0d, required 3/1", w2_drop_cnt, w2_overflow);
    end
    n_checks++;
    if (drop_cnt !== 8'(m_drops) || m_drops != 5) begin
      n_fail++;
      $display("FAIL drop_count_wide: got drop=%0d model=%0d, required 5", drop_cnt, m_drops);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 40; f++) begin
      toggle_frame($urandom_range(4095), $urandom_range(4095), $urandom_range(4095), $urandom_range(4095));
      for (int g = 0, gap = $urandom_range(8, 1); g < gap; g++) begin
        ch_ready = ($urandom_range(1) != 0);
        tick();
      end
    end
    ch_ready = 1'b1;
    repeat (40) tick();
    n_checks++;
    if (exp_beats.size() != 0 || ch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got pending=%0d valid=%0d, required 0/0", exp_beats.size(), ch_valid);
    end
    n_checks++;
    if (drop_cnt !== 8'(m_drops) || overflow !== (m_drops != 0)) begin
      n_fail++;
      $display("FAIL random_drops: got drop=%0d ovf=%0d, required %0d/%0d",
               drop_cnt, overflow, m_drops, (m_drops != 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    smp_clk = 1'b0;
    ch_ready = 1'b0;
    data_in1 = '0; data_in2 = '0; data_in3 = '0; data_in4 = '0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_behaviour();
    test_drop_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
